// File: rtl/regfile_wr_merge.sv
// Integer register file merging core writeback with a FIFO-buffered, non-stallable divider writeback.
// Optional REGFILE_RD_FWD_EN: read ports forward the value (and pending clear) committing this cycle.
module regfile_wr_merge #(
    parameter int data_width    = 32,
    parameter int num_regs      = 32,
    parameter int fifo_depth    = 2,
    parameter int reg_sel_width = $clog2(num_regs)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             core_wr_req,
    input  logic [reg_sel_width-1:0]         core_wr_sel,
    input  logic [data_width-1:0]            core_wr_data,
    input  logic                             div_wr_req,
    input  logic [reg_sel_width-1:0]         div_wr_sel,
    input  logic [data_width-1:0]            div_wr_data,
    input  logic                             pend_set_req,
    input  logic [reg_sel_width-1:0]         pend_quot_sel,
    input  logic [reg_sel_width-1:0]         pend_mod_sel,
    input  logic [reg_sel_width-1:0]         rd_sel1,
    input  logic [reg_sel_width-1:0]         rd_sel2,
    output logic [data_width-1:0]            rd_data1,
    output logic [data_width-1:0]            rd_data2,
    output logic                             rd_pend1,
    output logic                             rd_pend2,
    output logic [$clog2(fifo_depth+1)-1:0]  fifo_count,
    output logic                             overflow
);

    localparam int cnt_width = $clog2(fifo_depth + 1);
    localparam int ptr_width = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
    localparam logic [cnt_width-1:0] depth_c  = cnt_width'(fifo_depth);
    localparam logic [ptr_width-1:0] last_ptr = ptr_width'(fifo_depth - 1);

    // Architectural state
    logic [data_width-1:0]    regs [num_regs];
    logic [num_regs-1:0]      pending;

    // Divider write FIFO (circular buffer)
    logic [reg_sel_width-1:0] fifo_sel  [fifo_depth];
    logic [data_width-1:0]    fifo_data [fifo_depth];
    logic [ptr_width-1:0]     rd_ptr;
    logic [ptr_width-1:0]     wr_ptr;
    logic [cnt_width-1:0]     count;
    logic                     overflow_q;

    // Per-cycle decisions
    logic                     core_valid;
    logic                     div_valid;
    logic                     fifo_empty;
    logic                     fifo_full;
    logic                     pop;
    logic                     push;
    logic                     bypass;
    logic                     drop;
    logic                     commit_en;
    logic [reg_sel_width-1:0] commit_sel;
    logic [data_width-1:0]    commit_data;
    logic                     div_commit;
    logic [reg_sel_width-1:0] div_commit_sel;
    logic [num_regs-1:0]      pend_set_vec;
    logic [num_regs-1:0]      pend_clr_vec;
    logic [num_regs-1:0]      pending_next;

    assign core_valid = core_wr_req && (core_wr_sel != '0);
    assign div_valid  = div_wr_req && (div_wr_sel != '0);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == depth_c);

    // Core owns the write port; the FIFO head drains before any new divider result may bypass.
    assign pop    = !core_valid && !fifo_empty;
    assign bypass = !core_valid && fifo_empty && div_valid;
    assign push   = div_valid && !bypass && (!fifo_full || pop);
    assign drop   = div_valid && !bypass && fifo_full && !pop;

    always_comb begin
        commit_en      = 1'b0;
        commit_sel     = '0;
        commit_data    = '0;
        div_commit     = 1'b0;
        div_commit_sel = '0;
        if (core_valid) begin
            commit_en   = 1'b1;
            commit_sel  = core_wr_sel;
            commit_data = core_wr_data;
        end else if (pop) begin
            commit_en      = 1'b1;
            commit_sel     = fifo_sel[rd_ptr];
            commit_data    = fifo_data[rd_ptr];
            div_commit     = 1'b1;
            div_commit_sel = fifo_sel[rd_ptr];
        end else if (bypass) begin
            commit_en      = 1'b1;
            commit_sel     = div_wr_sel;
            commit_data    = div_wr_data;
            div_commit     = 1'b1;
            div_commit_sel = div_wr_sel;
        end
    end

    // Set wins over a same-cycle clear so a freshly issued divide is never lost.
    always_comb begin
        pend_set_vec = '0;
        pend_clr_vec = '0;
        if (pend_set_req) begin
            if (pend_quot_sel != '0) pend_set_vec[pend_quot_sel] = 1'b1;
            if (pend_mod_sel != '0)  pend_set_vec[pend_mod_sel]  = 1'b1;
        end
        if (div_commit && (div_commit_sel != '0)) pend_clr_vec[div_commit_sel] = 1'b1;
        pending_next = (pending & ~pend_clr_vec) | pend_set_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < num_regs; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (commit_en) regs[commit_sel] <= commit_data;
            pending <= pending_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < fifo_depth; i++) begin
                fifo_sel[i]  <= '0;
                fifo_data[i] <= '0;
            end
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                fifo_sel[wr_ptr]  <= div_wr_sel;
                fifo_data[wr_ptr] <= div_wr_data;
                wr_ptr <= (wr_ptr == last_ptr) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == last_ptr) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) overflow_q <= 1'b1;
        end
    end

    assign fifo_count = count;
    assign overflow   = overflow_q;

`ifdef REGFILE_RD_FWD_EN
    always_comb begin
        rd_data1 = regs[rd_sel1];
        rd_data2 = regs[rd_sel2];
        if (commit_en && (commit_sel == rd_sel1)) rd_data1 = commit_data;
        if (commit_en && (commit_sel == rd_sel2)) rd_data2 = commit_data;
        if (rd_sel1 == '0) rd_data1 = '0;
        if (rd_sel2 == '0) rd_data2 = '0;
        // Show a same-cycle clear unless the same register is being re-set.
        rd_pend1 = (rd_sel1 != '0) && pending[rd_sel1]
                   && !(pend_clr_vec[rd_sel1] && !pend_set_vec[rd_sel1]);
        rd_pend2 = (rd_sel2 != '0) && pending[rd_sel2]
                   && !(pend_clr_vec[rd_sel2] && !pend_set_vec[rd_sel2]);
    end
`else
    always_comb begin
        rd_data1 = (rd_sel1 == '0) ? '0 : regs[rd_sel1];
        rd_data2 = (rd_sel2 == '0) ? '0 : regs[rd_sel2];
        rd_pend1 = (rd_sel1 != '0) && pending[rd_sel1];
        rd_pend2 = (rd_sel2 != '0) && pending[rd_sel2];
    end
`endif

endmodule

// File: tb/tb_regfile_wr_merge.sv
// Directed bench for regfile_wr_merge: reset, bypass, FIFO merge, overflow, same-cycle ordering, mid-run reset.
module tb_regfile_wr_merge;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_wr_req;
    logic [4:0]  core_wr_sel;
    logic [31:0] core_wr_data;
    logic        div_wr_req;
    logic [4:0]  div_wr_sel;
    logic [31:0] div_wr_data;
    logic        pend_set_req;
    logic [4:0]  pend_quot_sel;
    logic [4:0]  pend_mod_sel;
    logic [4:0]  rd_sel1;
    logic [4:0]  rd_sel2;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic        rd_pend1;
    logic        rd_pend2;
    logic [1:0]  fifo_count;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_merge dut (
        .clk(clk), .rst(rst),
        .core_wr_req(core_wr_req), .core_wr_sel(core_wr_sel), .core_wr_data(core_wr_data),
        .div_wr_req(div_wr_req), .div_wr_sel(div_wr_sel), .div_wr_data(div_wr_data),
        .pend_set_req(pend_set_req), .pend_quot_sel(pend_quot_sel), .pend_mod_sel(pend_mod_sel),
        .rd_sel1(rd_sel1), .rd_sel2(rd_sel2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .rd_pend1(rd_pend1), .rd_pend2(rd_pend2),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        core_wr_req   = 1'b0;
        core_wr_sel   = '0;
        core_wr_data  = '0;
        div_wr_req    = 1'b0;
        div_wr_sel    = '0;
        div_wr_data   = '0;
        pend_set_req  = 1'b0;
        pend_quot_sel = '0;
        pend_mod_sel  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core(input logic [4:0] sel, input logic [31:0] data);
        core_wr_req  = 1'b1;
        core_wr_sel  = sel;
        core_wr_data = data;
    endtask

    task automatic div(input logic [4:0] sel, input logic [31:0] data);
        div_wr_req  = 1'b1;
        div_wr_sel  = sel;
        div_wr_data = data;
    endtask

    task automatic pset(input logic [4:0] q, input logic [4:0] m);
        pend_set_req  = 1'b1;
        pend_quot_sel = q;
        pend_mod_sel  = m;
    endtask

    task automatic rd(input string tag, input logic [4:0] sel, input logic [31:0] exp_d,
                      input logic exp_p);
        rd_sel1 = sel;
        rd_sel2 = sel;
        #1;
        check({tag, ".d1"}, rd_data1, exp_d);
        check({tag, ".d2"}, rd_data2, exp_d);
        check({tag, ".p1"}, 32'(rd_pend1), 32'(exp_p));
    endtask

    task automatic stat(input string tag, input logic [1:0] cnt, input logic ovf);
        check({tag, ".cnt"}, 32'(fifo_count), 32'(cnt));
        check({tag, ".ovf"}, 32'(overflow), 32'(ovf));
    endtask

    initial begin
        idle();
        rd_sel1 = '0;
        rd_sel2 = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        stat("reset", 2'd0, 1'b0);
        for (int i = 0; i < 32; i++) rd("reset_rd", 5'(i), 32'h0, 1'b0);

        // x0 is hardwired
        core(5'd0, 32'hDEAD);
        tick();
        idle();
        rd("x0", 5'd0, 32'h0, 1'b0);
        stat("x0", 2'd0, 1'b0);

        // Pending set, then bypass commit of x5
        pset(5'd5, 5'd6);
        tick();
        idle();
        rd("pset5", 5'd5, 32'h0, 1'b1);
        rd("pset6", 5'd6, 32'h0, 1'b1);
        div(5'd5, 32'd7);
        tick();
        idle();
        rd("byp5", 5'd5, 32'd7, 1'b0);
        rd("byp6", 5'd6, 32'h0, 1'b1);
        stat("byp", 2'd0, 1'b0);

        // Core holds the port; divider results queue up then drain in order
        core(5'd3, 32'h11);
        div(5'd5, 32'd9);
        pset(5'd5, 5'd0);
        tick();
        idle();
        stat("q1", 2'd1, 1'b0);
        core(5'd3, 32'h11);
        div(5'd6, 32'd2);
        tick();
        idle();
        stat("q2", 2'd2, 1'b0);
        core(5'd3, 32'h11);
        tick();
        idle();
        stat("q3", 2'd2, 1'b0);
        rd("q3_x5", 5'd5, 32'd7, 1'b1);
        rd("q3_x3", 5'd3, 32'h11, 1'b0);
        tick();
        rd("drain_x5", 5'd5, 32'd9, 1'b0);
        rd("drain_x6a", 5'd6, 32'h0, 1'b1);
        stat("drain1", 2'd1, 1'b0);
        tick();
        rd("drain_x6b", 5'd6, 32'd2, 1'b0);
        stat("drain2", 2'd0, 1'b0);

        // Overflow: three divider writes behind a busy core
        core(5'd3, 32'h22);
        div(5'd10, 32'd1);
        tick();
        core(5'd3, 32'h22);
        div(5'd11, 32'd2);
        tick();
        stat("ovf2", 2'd2, 1'b0);
        core(5'd3, 32'h22);
        div(5'd12, 32'd3);
        tick();
        idle();
        stat("ovf3", 2'd2, 1'b1);
        core(5'd3, 32'h22);
        tick();
        idle();
        stat("ovf4", 2'd2, 1'b1);
        // Push and pop while full
        div(5'd13, 32'h44);
        tick();
        idle();
        rd("pp_x10", 5'd10, 32'd1, 1'b0);
        stat("pp", 2'd2, 1'b1);
        tick();
        rd("pp_x11", 5'd11, 32'd2, 1'b0);
        tick();
        rd("pp_x13", 5'd13, 32'h44, 1'b0);
        rd("pp_x12", 5'd12, 32'h0, 1'b0);
        stat("ovf_end", 2'd0, 1'b1);

        // Same-cycle core and divider to x7; then set/clear collision on pend7
        pset(5'd7, 5'd0);
        tick();
        idle();
        core(5'd7, 32'd1);
        div(5'd7, 32'd2);
        tick();
        idle();
        rd("same_x7a", 5'd7, 32'd1, 1'b1);
        stat("same", 2'd1, 1'b1);
        pset(5'd7, 5'd0);
        tick();
        idle();
        rd("same_x7b", 5'd7, 32'd2, 1'b1);
        stat("same2", 2'd0, 1'b1);

        // Reset with a full FIFO
        core(5'd3, 32'h33);
        div(5'd20, 32'd5);
        tick();
        core(5'd3, 32'h33);
        div(5'd21, 32'd6);
        tick();
        idle();
        stat("prerst", 2'd2, 1'b1);
        rst = 1'b1;
        #1;
        stat("midrst", 2'd0, 1'b0);
        rd("midrst_x3", 5'd3, 32'h0, 1'b0);
        rd("midrst_x7", 5'd7, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        tick();
        rd("postrst_x20", 5'd20, 32'h0, 1'b0);
        rd("postrst_x21", 5'd21, 32'h0, 1'b0);
        stat("postrst", 2'd0, 1'b0);

        // Read of x9 while its divider result bypasses into the array
        pset(5'd9, 5'd0);
        tick();
        idle();
        div(5'd9, 32'h55);
        rd_sel1 = 5'd9;
        rd_sel2 = 5'd9;
        #1;
`ifdef REGFILE_RD_FWD_EN
        check("fwd_d", rd_data1, 32'h55);
        check("fwd_p", 32'(rd_pend1), 32'h0);
`else
        check("nofwd_d", rd_data1, 32'h0);
        check("nofwd_p", 32'(rd_pend1), 32'h1);
`endif
        tick();
        idle();
        rd("x9", 5'd9, 32'h55, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
